// File: rtl/mdu_hilo_pkg.sv
// Shared MDU definitions: op encodings, FSM states, divider iteration count.
// The DIV state only exists when MDU_DIVIDER_EN is defined.
package mdu_hilo_pkg;

    localparam int unsigned MDU_XLEN   = 32;
    localparam int unsigned MDU_ITERS  = 32;
    localparam int unsigned MDU_ITER_W = $clog2(MDU_ITERS);

    localparam logic [1:0] MDU_MULT  = 2'b00;
    localparam logic [1:0] MDU_MULTU = 2'b01;
    localparam logic [1:0] MDU_DIV   = 2'b10;
    localparam logic [1:0] MDU_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        MUL  = 2'b01,
`ifdef MDU_DIVIDER_EN
        DIV  = 2'b10,
`endif
        FIN  = 2'b11
    } mdu_state_t;

    // Operation captured when start is accepted
    typedef struct packed {
        logic [1:0]          op;
        logic [MDU_XLEN-1:0] a;
        logic [MDU_XLEN-1:0] b;
    } mdu_req_t;

    function automatic logic mdu_is_signed(input logic [1:0] op);
        return (op == MDU_MULT) || (op == MDU_DIV);
    endfunction

    function automatic logic mdu_is_div(input logic [1:0] op);
        return !((op == MDU_MULT) || (op == MDU_MULTU));
    endfunction

endpackage

// File: rtl/mdu_hilo_if.sv
// Pipeline <-> MDU request / HI-LO bus.
interface mdu_hilo_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        WriteHiLoW;
    logic        HiorLoW;
    logic [31:0] wdataW;
    logic        busy;
    logic        done;
    logic [31:0] hi_out;
    logic [31:0] lo_out;

    modport master (
        output start, op, a, b, flush, WriteHiLoW, HiorLoW, wdataW,
        input  busy, done, hi_out, lo_out
    );

    modport slave (
        input  start, op, a, b, flush, WriteHiLoW, HiorLoW, wdataW,
        output busy, done, hi_out, lo_out
    );
endinterface

// File: rtl/mdu_div_iter.sv
// Iterative restoring radix-2 divider: one setup cycle (absolute values,
// zero-divisor detect) followed by MDU_ITERS iterations.
module mdu_div_iter
    import mdu_hilo_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    input  logic                isSigned,
    input  logic [MDU_XLEN-1:0] dividend,
    input  logic [MDU_XLEN-1:0] divisor,
    output logic                done_c,
    output logic                divZero_c,
    output logic [MDU_XLEN-1:0] quot_c,
    output logic [MDU_XLEN-1:0] rem_c
);
    logic                  running, setup, sgn, negQ, negR;
    logic [MDU_ITER_W-1:0] iterCnt;
    logic [MDU_XLEN-1:0]   qReg, rReg, dsr;
    logic [MDU_XLEN:0]     remShift_c;
    logic [MDU_XLEN-1:0]   diff_c, absDvd_c, absDsr_c;
    logic                  fits_c;

    // Trial subtraction, sign fix-up and handshake flags
    always_comb begin
        remShift_c = {rReg, qReg[MDU_XLEN-1]};
        fits_c     = remShift_c >= {1'b0, dsr};
        diff_c     = remShift_c[MDU_XLEN-1:0] - dsr;
        absDvd_c   = (sgn && qReg[MDU_XLEN-1]) ? (~qReg + MDU_XLEN'(1)) : qReg;
        absDsr_c   = (sgn && dsr[MDU_XLEN-1])  ? (~dsr + MDU_XLEN'(1))  : dsr;
        done_c     = running && !setup && (iterCnt == MDU_ITER_W'(MDU_ITERS - 1));
        divZero_c  = running && setup && (dsr == '0);
        quot_c     = negQ ? (~qReg + MDU_XLEN'(1)) : qReg;
        rem_c      = negR ? (~rReg + MDU_XLEN'(1)) : rReg;
    end

    // Operand load, setup and shift/subtract iterations
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            running <= 1'b0;
            setup   <= 1'b0;
            sgn     <= 1'b0;
            negQ    <= 1'b0;
            negR    <= 1'b0;
            iterCnt <= '0;
            qReg    <= '0;
            rReg    <= '0;
            dsr     <= '0;
        end else if (abort) begin
            running <= 1'b0;
            setup   <= 1'b0;
        end else if (start) begin
            running <= 1'b1;
            setup   <= 1'b1;
            sgn     <= isSigned;
            iterCnt <= '0;
            qReg    <= dividend;
            rReg    <= '0;
            dsr     <= divisor;
        end else if (running && setup) begin
            setup <= 1'b0;
            if (dsr == '0) begin
                running <= 1'b0;
            end else begin
                qReg <= absDvd_c;
                dsr  <= absDsr_c;
                negQ <= sgn && (qReg[MDU_XLEN-1] ^ dsr[MDU_XLEN-1]);
                negR <= sgn && qReg[MDU_XLEN-1];
            end
        end else if (running) begin
            rReg    <= fits_c ? diff_c : remShift_c[MDU_XLEN-1:0];
            qReg    <= {qReg[MDU_XLEN-2:0], fits_c};
            iterCnt <= iterCnt + MDU_ITER_W'(1);
            if (done_c) running <= 1'b0;
        end
    end
endmodule

// File: rtl/mdu_hilo.sv
// MDU with HI/LO registers: 2-cycle multiply, optional iterative divide
// (enabled by MDU_DIVIDER_EN), write-stage MTHI/MTLO moves.
module mdu_hilo
    import mdu_hilo_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    mdu_hilo_if.slave  bus
);
    mdu_state_t          state, stateNext;
    mdu_req_t            reqR;
    logic                mulCnt;
    logic [2*MDU_XLEN-1:0] prodR, aExt_c, bExt_c, prod_c;
    logic [MDU_XLEN-1:0] hiR, loR, resHi_c, resLo_c;
    logic                finWr_c, divStart_c, sgn_c;

`ifdef MDU_DIVIDER_EN
    logic                divDone_c, divZero_c;
    logic [MDU_XLEN-1:0] divQuot_c, divRem_c;

    mdu_div_iter u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (divStart_c),
        .abort     (bus.flush && (state == DIV)),
        .isSigned  (mdu_is_signed(bus.op)),
        .dividend  (bus.a),
        .divisor   (bus.b),
        .done_c    (divDone_c),
        .divZero_c (divZero_c),
        .quot_c    (divQuot_c),
        .rem_c     (divRem_c)
    );
`endif

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= stateNext;
    end

    // Next state, busy/done and result write enable
    always_comb begin
        stateNext  = state;
        finWr_c    = 1'b0;
        divStart_c = 1'b0;
        unique case (state)
            IDLE: if (bus.start) begin
`ifdef MDU_DIVIDER_EN
                divStart_c = mdu_is_div(bus.op);
                stateNext  = mdu_is_div(bus.op) ? DIV : MUL;
`else
                stateNext  = mdu_is_div(bus.op) ? FIN : MUL;
`endif
            end
            MUL: begin
                if (bus.flush)   stateNext = IDLE;
                else if (mulCnt) stateNext = FIN;
            end
`ifdef MDU_DIVIDER_EN
            DIV: begin
                if (bus.flush || divZero_c) stateNext = IDLE;
                else if (divDone_c)         stateNext = FIN;
            end
            FIN: begin
                stateNext = IDLE;
                finWr_c   = !bus.flush;
            end
`else
            FIN: begin
                stateNext = IDLE;
                finWr_c   = !bus.flush && !mdu_is_div(reqR.op);
            end
`endif
            default: stateNext = IDLE;
        endcase
        bus.busy = (state != IDLE);
        bus.done = finWr_c;
    end

    // Multiplier operands sign/zero extended to 64 bits; low 64 bits are exact
    always_comb begin
        sgn_c  = mdu_is_signed(reqR.op);
        aExt_c = {{MDU_XLEN{sgn_c && reqR.a[MDU_XLEN-1]}}, reqR.a};
        bExt_c = {{MDU_XLEN{sgn_c && reqR.b[MDU_XLEN-1]}}, reqR.b};
        prod_c = aExt_c * bExt_c;
`ifdef MDU_DIVIDER_EN
        if (mdu_is_div(reqR.op)) begin
            resHi_c = divRem_c;
            resLo_c = divQuot_c;
        end else begin
            resHi_c = prodR[2*MDU_XLEN-1:MDU_XLEN];
            resLo_c = prodR[MDU_XLEN-1:0];
        end
`else
        resHi_c = prodR[2*MDU_XLEN-1:MDU_XLEN];
        resLo_c = prodR[MDU_XLEN-1:0];
`endif
    end

    // Request capture, multiply cycle counter and product register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            reqR   <= '0;
            mulCnt <= 1'b0;
            prodR  <= '0;
        end else begin
            if ((state == IDLE) && bus.start) begin
                reqR.op <= bus.op;
                reqR.a  <= bus.a;
                reqR.b  <= bus.b;
            end
            mulCnt <= ((state == MUL) && !bus.flush) ? ~mulCnt : 1'b0;
            if (state == MUL) prodR <= prod_c;
        end
    end

    // HI/LO: MDU result beats a coincident write-stage move
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hiR <= '0;
            loR <= '0;
        end else if (finWr_c) begin
            hiR <= resHi_c;
            loR <= resLo_c;
        end else if (bus.WriteHiLoW) begin
            if (bus.HiorLoW) hiR <= bus.wdataW;
            else             loR <= bus.wdataW;
        end
    end

    assign bus.hi_out = hiR;
    assign bus.lo_out = loR;
endmodule

// File: tb/tb_mdu_hilo.sv
// Scoreboard bench for mdu_hilo; divide expectations follow MDU_DIVIDER_EN.
module tb_mdu_hilo;
    import mdu_hilo_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    logic [31:0] modelHi = '0;
    logic [31:0] modelLo = '0;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          tag;
    } exp_t;
    exp_t expQ[$];

    mdu_hilo_if bus();

    mdu_hilo dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest expected result
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                @(posedge clk);
                #1;
                checks++;
                if (expQ.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected_done actual=1 required=0 at %0t", $time);
                end else begin
                    e = expQ.pop_front();
                    check($sformatf("sb_hi tag=%0d", e.tag), bus.hi_out, e.hi);
                    check($sformatf("sb_lo tag=%0d", e.tag), bus.lo_out, e.lo);
                end
            end
        end
    end

    task automatic move(input logic toHi, input logic [31:0] d);
        @(posedge clk); #1;
        bus.WriteHiLoW = 1'b1; bus.HiorLoW = toHi; bus.wdataW = d;
        @(posedge clk); #1;
        bus.WriteHiLoW = 1'b0;
        if (toHi) modelHi = d; else modelLo = d;
    endtask

    // Issue start for one cycle, then scramble operands
    task automatic startOp(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        @(posedge clk); #1;
        bus.start = 1'b1; bus.op = o; bus.a = x; bus.b = y;
        @(negedge clk);
        check("busy_in_start_cycle", 32'(bus.busy), 32'd0);
        @(posedge clk); #1;
        bus.start = 1'b0; bus.a = ~x; bus.b = y ^ 32'h5555_5555;
    endtask

    task automatic waitIdle(output int nBusy, output int doneAt);
        bit idle = 1'b0;
        nBusy = 0; doneAt = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!bus.busy) begin idle = 1'b1; break; end
            nBusy++;
            if (bus.done) doneAt = nBusy;
        end
        if (!idle) begin
            checks++; errors++;
            $display("FAIL wait_idle_timeout busy_cycles=%0d limit=100", nBusy);
        end
    endtask

    task automatic runOp(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] eh, input logic [31:0] el, input int lat, input int tag);
        int n, d;
        expQ.push_back('{hi: eh, lo: el, tag: tag});
        modelHi = eh; modelLo = el;
        startOp(o, x, y);
        waitIdle(n, d);
        check($sformatf("busy_cycles tag=%0d", tag), n, lat);
        check($sformatf("done_cycle tag=%0d", tag), d, lat);
    endtask

    // Operation that must leave HI/LO alone and never pulse done
    task automatic runNoResult(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, input int tag);
        int n, d;
        startOp(o, x, y);
        waitIdle(n, d);
        check($sformatf("noresult_busy tag=%0d", tag), n, 1);
        check($sformatf("noresult_done tag=%0d", tag), d, 0);
        check($sformatf("noresult_hi tag=%0d", tag), bus.hi_out, modelHi);
        check($sformatf("noresult_lo tag=%0d", tag), bus.lo_out, modelLo);
    endtask

    initial begin
        int n, d;
        rst = 1'b0;
        bus.start = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0; bus.flush = 1'b0;
        bus.WriteHiLoW = 1'b0; bus.HiorLoW = 1'b0; bus.wdataW = '0;
        #12;
        check("rst_hi", bus.hi_out, 32'd0);
        check("rst_lo", bus.lo_out, 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        @(negedge clk); rst = 1'b1;

        // Moves in IDLE
        move(1'b1, 32'h1111_2222);
        move(1'b0, 32'hA5A5_A5A5);
        @(negedge clk);
        check("mtlo_lo", bus.lo_out, 32'hA5A5_A5A5);
        check("mtlo_hi_kept", bus.hi_out, 32'h1111_2222);

        // Multiplies
        runOp(MDU_MULT,  32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 3, 1);
        runOp(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 3, 2);
        runOp(MDU_MULT,  32'h7FFF_FFFF, 32'h8000_0000, 32'hC000_0000, 32'h8000_0000, 3, 3);
        runOp(MDU_MULTU, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780, 3, 4);

        // Move during MUL, then FIN coinciding with MTHI
        expQ.push_back('{hi: 32'd0, lo: 32'd35, tag: 5});
        startOp(MDU_MULT, 32'd5, 32'd7);
        bus.WriteHiLoW = 1'b1; bus.HiorLoW = 1'b0; bus.wdataW = 32'hCAFE_F00D;
        @(posedge clk); #1;
        bus.WriteHiLoW = 1'b0;
        @(negedge clk);
        check("move_in_mul_lo", bus.lo_out, 32'hCAFE_F00D);
        check("busy_in_mul2", 32'(bus.busy), 32'd1);
        @(posedge clk); #1;
        bus.WriteHiLoW = 1'b1; bus.HiorLoW = 1'b1; bus.wdataW = 32'h1234_5678;
        @(negedge clk);
        check("fin_done", 32'(bus.done), 32'd1);
        @(posedge clk); #1;
        bus.WriteHiLoW = 1'b0;
        @(negedge clk);
        check("fin_busy_low", 32'(bus.busy), 32'd0);
        modelHi = 32'd0; modelLo = 32'd35;

        // Start while busy is ignored
        expQ.push_back('{hi: 32'd0, lo: 32'd9, tag: 6});
        startOp(MDU_MULTU, 32'd3, 32'd3);
        bus.start = 1'b1; bus.op = MDU_MULT; bus.a = 32'd100; bus.b = 32'd100;
        @(posedge clk); #1;
        bus.start = 1'b0;
        waitIdle(n, d);
        check("ignore_start_busy", n, 2);
        check("ignore_start_done", d, 2);
        @(negedge clk);
        check("ignore_start_idle", 32'(bus.busy), 32'd0);
        modelHi = 32'd0; modelLo = 32'd9;

        // Flush in MUL, then a new start is accepted
        startOp(MDU_MULT, 32'd9, 32'd9);
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        @(negedge clk);
        check("mul_flush_busy", 32'(bus.busy), 32'd0);
        check("mul_flush_hi", bus.hi_out, modelHi);
        check("mul_flush_lo", bus.lo_out, modelLo);
        runOp(MDU_MULTU, 32'd6, 32'd7, 32'd0, 32'd42, 3, 7);

`ifdef MDU_DIVIDER_EN
        runOp(MDU_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 34, 10);
        runOp(MDU_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 34, 11);
        runOp(MDU_DIV,  32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 34, 12);
        runOp(MDU_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 34, 13);
        runNoResult(MDU_DIV, 32'd1234, 32'd0, 14);
        // Flush on iteration 10 (busy cycle 11)
        startOp(MDU_DIV, 32'd1000, 32'd3);
        repeat (10) @(posedge clk);
        #1 bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        @(negedge clk);
        check("div_flush_busy", 32'(bus.busy), 32'd0);
        check("div_flush_hi", bus.hi_out, modelHi);
        check("div_flush_lo", bus.lo_out, modelLo);
        runOp(MDU_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 34, 15);
`else
        runNoResult(MDU_DIV,  32'hFFFF_FFF9, 32'd2, 20);
        runNoResult(MDU_DIVU, 32'd100, 32'd7, 21);
        runOp(MDU_MULT, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 3, 22);
`endif

        // Asynchronous reset in the middle of a multiply
        startOp(MDU_MULT, 32'd2, 32'd3);
        #2 rst = 1'b0;
        #1;
        check("async_rst_hi", bus.hi_out, 32'd0);
        check("async_rst_lo", bus.lo_out, 32'd0);
        check("async_rst_busy", 32'(bus.busy), 32'd0);
        modelHi = '0; modelLo = '0;
        @(negedge clk); rst = 1'b1;
        repeat (4) @(negedge clk);
        check("post_rst_busy", 32'(bus.busy), 32'd0);
        check("post_rst_lo", bus.lo_out, modelLo);

        repeat (2) @(negedge clk);
        check("sb_drained", 32'(expQ.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout time=%0t", $time);
        $fatal(1, "watchdog");
    end
endmodule
